// File: rtl/m_cpu_pkg.sv
// rtl/m_cpu_pkg.sv - shared widths, opcodes and instruction layout for the m_cpu pipeline
package m_cpu_pkg;

    localparam int N    = 16;
    localparam int SEL  = 4;
    localparam int NREG = 16;
    localparam int AW   = 4;

    localparam logic [SEL-1:0] OP_ADD = 4'd0;
    localparam logic [SEL-1:0] OP_SUB = 4'd1;
    localparam logic [SEL-1:0] OP_MUL = 4'd2;
    localparam logic [SEL-1:0] OP_DIV = 4'd3;
    localparam logic [SEL-1:0] OP_AND = 4'd4;
    localparam logic [SEL-1:0] OP_OR  = 4'd5;
    localparam logic [SEL-1:0] OP_XOR = 4'd6;
    localparam logic [SEL-1:0] OP_LI  = 4'd7;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;

    // Field order matches the instruction word MSB-first, so a plain cast decodes it.
    typedef struct packed {
        logic [SEL-1:0] opcode;
        logic [AW-1:0]  rd;
        logic [AW-1:0]  rs1;
        logic [AW-1:0]  rs2;
    } instr_t;

    // Opcodes 8..15 are reserved; the top opcode bit alone marks them.
    function automatic logic is_legal(input logic [SEL-1:0] opcode);
        return !opcode[SEL-1];
    endfunction

endpackage

// File: rtl/regfile_16x16.sv
// rtl/regfile_16x16.sv - 16x16 register file, two combinational reads, one synchronous write
module regfile_16x16
    import m_cpu_pkg::*;
(
    input  logic          clk,     // clock
    input  logic          rst,     // synchronous active-high reset, clears every entry
    input  logic [AW-1:0] raddr1,  // read port 1 address
    output logic [N-1:0]  rdata1,  // read port 1 data
    input  logic [AW-1:0] raddr2,  // read port 2 address
    output logic [N-1:0]  rdata2,  // read port 2 data
    input  logic          we,      // write strobe
    input  logic [AW-1:0] waddr,   // write address
    input  logic [N-1:0]  wdata    // write data
);

    logic [N-1:0] mem_q [NREG];
    logic [N-1:0] mem_d [NREG];

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                mem_q[i] <= '0;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/op_fetch_stage.sv
// rtl/op_fetch_stage.sv - decode/operand-fetch stage with busy scoreboard and writeback bypass
module op_fetch_stage
    import m_cpu_pkg::*;
(
    input  logic            clk,          // clock
    input  logic            rst,          // synchronous active-high reset
    input  logic            in_valid,     // instruction valid
    output logic            in_ready,     // stage can accept instruction
    input  logic [N-1:0]    instr,        // opcode / rd / rs1 / rs2 (imm8 for li)
    output logic            out_valid,    // operand bundle valid
    input  logic            out_ready,    // downstream accepts bundle
    output logic [SEL-1:0]  op_opcode,    // registered opcode
    output logic [AW-1:0]   rd_addr,      // registered destination
    output logic [N-1:0]    rs1_reg_val,  // registered rs1 operand
    output logic [N-1:0]    rs2_reg_val,  // registered rs2 operand or imm8
    input  logic            wb_en,        // writeback strobe
    input  logic [AW-1:0]   wb_addr,      // writeback register
    input  logic [N-1:0]    wb_data,      // writeback value
    output logic            illegal_op,   // one-cycle pulse on reserved opcode consumed
    output logic [NREG-1:0] busy_vec      // scoreboard state
);

    instr_t          dec;
    logic            legal;
    logic            is_li;
    logic            hazard;
    logic            accept;
    logic            accept_legal;
    logic            accept_illegal;
    logic [NREG-1:0] wb_vec;
    logic [NREG-1:0] free_vec;
    logic [N-1:0]    rf_rdata1;
    logic [N-1:0]    rf_rdata2;
    logic [N-1:0]    rs1_byp;
    logic [N-1:0]    rs2_byp;
    logic [N-1:0]    imm_ext;

    logic            out_valid_q,   out_valid_d;
    logic            illegal_q,     illegal_d;
    logic [NREG-1:0] busy_q,        busy_d;
    logic [SEL-1:0]  op_opcode_q,   op_opcode_d;
    logic [AW-1:0]   rd_addr_q,     rd_addr_d;
    logic [N-1:0]    rs1_val_q,     rs1_val_d;
    logic [N-1:0]    rs2_val_q,     rs2_val_d;

    regfile_16x16 u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (dec.rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (dec.rs2),
        .rdata2 (rf_rdata2),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    assign dec     = instr_t'(instr);
    assign legal   = is_legal(dec.opcode);
    assign is_li   = (dec.opcode == OP_LI);
    assign imm_ext = {{(N-IMM_W){1'b0}}, dec.rs1, dec.rs2};

    // One-hot of the register being written back this cycle.
    always_comb begin
        wb_vec = '0;
        if (wb_en) begin
            wb_vec[wb_addr] = 1'b1;
        end
    end

    // A busy register whose writeback lands this cycle counts as free,
    // because the bypass below delivers the value being written.
    assign free_vec = ~busy_q | wb_vec;

    // The rd term blocks a second write to a register with one already in flight.
    assign hazard = !free_vec[dec.rs1]
                  || (!is_li && !free_vec[dec.rs2])
                  || !free_vec[dec.rd];

    assign in_ready       = (!out_valid_q || out_ready) && !(legal && hazard);
    assign accept         = in_valid && in_ready;
    assign accept_legal   = accept && legal;
    assign accept_illegal = accept && !legal;

    assign rs1_byp = (wb_en && (wb_addr == dec.rs1)) ? wb_data : rf_rdata1;
    assign rs2_byp = (wb_en && (wb_addr == dec.rs2)) ? wb_data : rf_rdata2;

    always_comb begin
        out_valid_d = out_valid_q;
        op_opcode_d = op_opcode_q;
        rd_addr_d   = rd_addr_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        illegal_d   = accept_illegal;
        // Clear before set so an issue to the register being written back keeps it busy.
        busy_d      = busy_q & ~wb_vec;

        if (accept_legal) begin
            out_valid_d     = 1'b1;
            op_opcode_d     = dec.opcode;
            rd_addr_d       = dec.rd;
            rs1_val_d       = rs1_byp;
            rs2_val_d       = is_li ? imm_ext : rs2_byp;
            busy_d[dec.rd]  = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= '0;
            op_opcode_q <= '0;
            rd_addr_q   <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            op_opcode_q <= op_opcode_d;
            rd_addr_q   <= rd_addr_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign illegal_op  = illegal_q;
    assign busy_vec    = busy_q;
    assign op_opcode   = op_opcode_q;
    assign rd_addr     = rd_addr_q;
    assign rs1_reg_val = rs1_val_q;
    assign rs2_reg_val = rs2_val_q;

endmodule

// File: tb/tb_op_fetch_stage.sv
// tb/tb_op_fetch_stage.sv - scoreboard bench for op_fetch_stage
module tb_op_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  op_opcode;
    logic [3:0]  rd_addr;
    logic [15:0] rs1_reg_val;
    logic [15:0] rs2_reg_val;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        illegal_op;
    logic [15:0] busy_vec;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
    } bundle_t;

    bundle_t     exp_q[$];
    logic [15:0] mrf [16];
    int          checks = 0;
    int          errors = 0;

    op_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .op_opcode   (op_opcode),
        .rd_addr     (rd_addr),
        .rs1_reg_val (rs1_reg_val),
        .rs2_reg_val (rs2_reg_val),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal_op  (illegal_op),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [15:0] byp(input logic [3:0] r);
        return (wb_en && wb_addr == r) ? wb_data : mrf[r];
    endfunction

    // One clock: record the expected bundle for an accepted legal instruction,
    // track register-file contents, then land 1 time unit after the edge.
    task automatic step();
        bundle_t b;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) mrf[i] = 16'h0000;
        end else begin
            if (in_valid && in_ready && !instr[15]) begin
                b.op = instr[15:12];
                b.rd = instr[11:8];
                b.a  = byp(instr[7:4]);
                b.b  = (instr[15:12] == 4'd7) ? {8'h00, instr[7:0]} : byp(instr[3:0]);
                exp_q.push_back(b);
            end
            if (wb_en) mrf[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [3:0] a, input logic [15:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] i);
        in_valid = 1'b1; instr = i;
        step();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        bundle_t e;
        bundle_t got;
        if (!rst && out_valid && out_ready) begin
            checks++;
            got = {op_opcode, rd_addr, rs1_reg_val, rs2_reg_val};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bundle_unexpected got=%h", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL bundle got=%h exp=%h", got, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; instr = 16'h0000; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 4'h0; wb_data = 16'h0000;
        step(); step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL rst_illegal got=%b exp=0", illegal_op); end
        checks++; if (busy_vec !== 16'h0000) begin errors++; $display("FAIL rst_busy got=%h exp=0000", busy_vec); end
        checks++; if ({op_opcode, rd_addr, rs1_reg_val, rs2_reg_val} !== 40'h0) begin
            errors++; $display("FAIL rst_outputs got=%h exp=0", {op_opcode, rd_addr, rs1_reg_val, rs2_reg_val});
        end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic_add();
        wb(4'd1, 16'h0005);
        wb(4'd2, 16'h0003);
        issue(16'h0412);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if ({op_opcode, rd_addr} !== 8'h04) begin errors++; $display("FAIL add_op_rd got=%h exp=04", {op_opcode, rd_addr}); end
        checks++; if (rs1_reg_val !== 16'h0005 || rs2_reg_val !== 16'h0003) begin
            errors++; $display("FAIL add_operands got=%h/%h exp=0005/0003", rs1_reg_val, rs2_reg_val);
        end
        checks++; if (busy_vec !== 16'h0010) begin errors++; $display("FAIL add_busy got=%h exp=0010", busy_vec); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%b exp=0", out_valid); end
        wb(4'd4, 16'h0009);
        checks++; if (busy_vec !== 16'h0000) begin errors++; $display("FAIL add_release got=%h exp=0000", busy_vec); end
    endtask

    task automatic test_li_no_stall();
        issue(16'h0700);
        in_valid = 1'b1; instr = 16'h75A7;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL li_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (op_opcode !== 4'd7 || rd_addr !== 4'd5 || rs2_reg_val !== 16'h00A7) begin
            errors++; $display("FAIL li_bundle got=%h/%h/%h exp=7/5/00a7", op_opcode, rd_addr, rs2_reg_val);
        end
        checks++; if (busy_vec !== 16'h00A0) begin errors++; $display("FAIL li_busy got=%h exp=00a0", busy_vec); end
        step();
        wb(4'd7, 16'h0077);
        wb(4'd5, 16'h5555);
        checks++; if (busy_vec !== 16'h0000) begin errors++; $display("FAIL li_release got=%h exp=0000", busy_vec); end
    endtask

    task automatic test_raw();
        issue(16'h0412);
        in_valid = 1'b1; instr = 16'h1641;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall cycle=%0d got=%b exp=0", k, in_ready); end
            step();
        end
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h1234;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release got=%b exp=1", in_ready); end
        step();
        wb_en = 1'b0; in_valid = 1'b0;
        checks++; if (rs1_reg_val !== 16'h1234 || rs2_reg_val !== 16'h0005) begin
            errors++; $display("FAIL raw_bypass got=%h/%h exp=1234/0005", rs1_reg_val, rs2_reg_val);
        end
        checks++; if (busy_vec !== 16'h0040) begin errors++; $display("FAIL raw_busy got=%h exp=0040", busy_vec); end
        step();
        wb(4'd6, 16'h0006);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(16'h2312);
        in_valid = 1'b1; instr = 16'h4812;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cycle=%0d got=%b exp=0", k, in_ready); end
            checks++; if ({out_valid, op_opcode, rd_addr, rs1_reg_val, rs2_reg_val} !== {1'b1, 4'd2, 4'd3, 16'h0005, 16'h0003}) begin
                errors++; $display("FAIL bp_hold cycle=%0d got=%h exp=%h", k,
                    {out_valid, op_opcode, rd_addr, rs1_reg_val, rs2_reg_val}, {1'b1, 4'd2, 4'd3, 16'h0005, 16'h0003});
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || op_opcode !== 4'd4 || rd_addr !== 4'd8) begin
            errors++; $display("FAIL bp_no_bubble got=%b/%h/%h exp=1/4/8", out_valid, op_opcode, rd_addr);
        end
        step();
        wb(4'd3, 16'h0033);
        wb(4'd8, 16'h0088);
    endtask

    task automatic test_illegal();
        issue(16'h0912);
        step();
        in_valid = 1'b1; instr = 16'hB999;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_pulse got=%b exp=1", illegal_op); end
        checks++; if (out_valid !== 1'b0 || busy_vec !== 16'h0200 || rd_addr !== 4'd9 || op_opcode !== 4'd0) begin
            errors++; $display("FAIL ill_unchanged got=%b/%h/%h/%h exp=0/0200/9/0", out_valid, busy_vec, rd_addr, op_opcode);
        end
        step();
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_one_cycle got=%b exp=0", illegal_op); end
        wb(4'd9, 16'h0099);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = {4'(k), 4'(10 + k), 4'h1, 4'h2};
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || rd_addr !== 4'(10 + k)) begin
                errors++; $display("FAIL b2b_bundle k=%0d got=%b/%h exp=1/%h", k, out_valid, rd_addr, 4'(10 + k));
            end
        end
        instr = 16'h7A00;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got=%b exp=0", in_ready); end
        step();
        wb_en = 1'b1; wb_addr = 4'd10; wb_data = 16'h0A0A;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_wb_free got=%b exp=1", in_ready); end
        step();
        wb_en = 1'b0; in_valid = 1'b0;
        checks++; if (busy_vec !== 16'h3C00) begin errors++; $display("FAIL set_wins got=%h exp=3c00", busy_vec); end
        step();
        for (int k = 0; k < 4; k++) wb(4'(10 + k), 16'(k));
        checks++; if (busy_vec !== 16'h0000) begin errors++; $display("FAIL b2b_release got=%h exp=0000", busy_vec); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        issue(16'h0412);
        issue(16'h0512);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || busy_vec !== 16'h0030) begin
            errors++; $display("FAIL pre_rst got=%b/%h exp=1/0030", out_valid, busy_vec);
        end
        rst = 1'b1;
        wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'hFFFF;
        step();
        rst = 1'b0; wb_en = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy_vec !== 16'h0000) begin
            errors++; $display("FAIL mid_rst got=%b/%h exp=0/0000", out_valid, busy_vec);
        end
        out_ready = 1'b1;
        issue(16'h0012);
        checks++; if (out_valid !== 1'b1 || rs1_reg_val !== 16'h0000 || rs2_reg_val !== 16'h0000) begin
            errors++; $display("FAIL rf_cleared got=%b/%h/%h exp=1/0000/0000", out_valid, rs1_reg_val, rs2_reg_val);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_li_no_stall();
        test_raw();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_reset_midflight();
        step();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/op_fetch_stage.md
Name: op_fetch_stage

Overview:
- Decode/operand-fetch stage of the 16-bit m_cpu pipeline, directly upstream of the rs2 demux and its rs1 counterpart.
- Accepts one 16-bit instruction per handshake and reads rs1/rs2 from an internal 16x16 register file.
- Resolves RAW/WAW hazards with a busy scoreboard plus writeback bypass.
- Presents op_opcode, rd_addr, rs1_reg_val and rs2_reg_val in an output register under valid/ready.
- Also owns the register-file write port, driven by the downstream writeback.

Parameters:
- N, 16, data width
- SEL, 4, opcode width
- NREG, 16, register count (address width 4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept instruction
- instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2 / [7:0] imm8 for li
- out_valid  out  1  operand bundle valid
- out_ready  in  1  downstream accepts bundle
- op_opcode  out  SEL  registered opcode (feeds demux select)
- rd_addr  out  4  registered destination
- rs1_reg_val  out  N  registered rs1 operand
- rs2_reg_val  out  N  registered rs2 operand (demux data input)
- wb_en  in  1  writeback strobe
- wb_addr  in  4  writeback register
- wb_data  in  N  writeback value
- illegal_op  out  1  one-cycle pulse, opcode 8..15 consumed
- busy_vec  out  NREG  scoreboard state (debug / verification)

Behaviour:
- Reset (clk edge with rst=1):
  - out_valid=0, illegal_op=0, busy_vec=0.
  - op_opcode, rd_addr, rs1_reg_val, rs2_reg_val all 0.
  - All register-file entries 0.
  - rst overrides all in-flight state: pending bundle dropped, writeback that cycle ignored.
- Register free test: reg r is free if busy[r]==0, or if wb_en && wb_addr==r in the same cycle.
- hazard (legal opcode 0..7) is high if any of the following is not free:
  - rs1;
  - rs2, only when opcode!=7;
  - rd.
  - The rd term is the WAW check; it guarantees at most one write in flight per register.
- in_ready = (!out_valid || out_ready) && !(legal && hazard). Computed combinationally from instr, so in_ready may depend on instr.
- Accept = in_valid && in_ready.
- Legal accept: next edge loads the output register and sets out_valid=1. Latency is 1 cycle.
  - op_opcode <= opcode, rd_addr <= rd.
  - rs1_reg_val <= bypass(rs1).
  - rs2_reg_val <= (opcode==7) ? {8'h00, imm8} : bypass(rs2).
  - busy[rd] <= 1.
- bypass(r) = (wb_en && wb_addr==r) ? wb_data : rf[r]. Register file is written at the clock edge; reads are combinational.
- Illegal accept (opcode>=8):
  - Instruction consumed; output register and scoreboard unchanged.
  - illegal_op=1 for exactly the next cycle.
  - Hazard check not applied.
- Output hold: out_valid && !out_ready holds all outputs stable, and no legal accept occurs.
  - Illegal opcodes are also blocked in this state, because in_ready=0 when out_valid && !out_ready.
- out_valid clear: out_valid && out_ready with no new accept sets out_valid to 0 on the next edge. Back-to-back bundles are allowed (full throughput when there are no hazards).
- Writeback:
  - wb_en writes rf[wb_addr]<=wb_data and clears busy[wb_addr].
  - If a legal accept sets busy for the same register in the same cycle, the set wins and busy stays 1.
  - wb_en to a register that is not busy still writes the file; busy is unchanged.
- Width: all operands are N bits. imm8 is zero-extended. No arithmetic is performed in this stage.

Decomposition:
- Package m_cpu_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_LI=7;
  - instruction field bit positions;
  - N / SEL defaults.
- One sub-module: regfile_16x16 (2 combinational read ports, 1 synchronous write port, synchronous reset), reused by later stages.
- Scoreboard, bypass and output register live in op_fetch_stage.

Test Plan:
- Reset, then wb 3:r1=0x0005 and r2=0x0003; issue ADD rd=4, rs1=1, rs2=2 -> out_valid next cycle; op_opcode=0, rd_addr=4, rs1=0x0005, rs2=0x0003; busy_vec=0x0010.
- LI rd=5, imm8=0xA7 while r7 is busy -> no stall; rs2_reg_val=0x00A7; busy_vec bit5 set.
- RAW: issue ADD rd=4; next cycle issue SUB rs1=4 -> in_ready=0 until wb_en addr=4 data=0x1234. In that same cycle SUB is accepted with rs1_reg_val=0x1234 (bypass).
- Backpressure: hold out_ready=0 for 3 cycles with a valid bundle -> outputs stable, in_ready=0. out_ready=1 with a queued instruction -> new bundle on the next edge, no bubble.
- Opcode 0xB -> consumed; illegal_op high exactly 1 cycle; out_valid and busy_vec unchanged.
- Assert rst while out_valid=1 and busy_vec=0x0030 -> out_valid=0, busy_vec=0, and rf reads 0 after the reset edge.
